branch_predictor: RTL and testbench



---
 rtl/branch_predictor_if.sv | 23 ++
 rtl/branch_predictor.sv | 105 ++++++++++
 tb/tb_branch_predictor.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and execute-side training signals of the branch predictor.
// The fetch/EXE logic drives through master; the predictor uses slave.
interface branch_predictor_if;
    logic        clr;
    logic [31:0] if_pc;
    logic        predict_jump;
    logic [31:0] predict_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_jump;
    logic [31:0] upd_target;

    modport master (
        output clr, if_pc, upd_valid, upd_pc, upd_taken, upd_jump, upd_target,
        input  predict_jump, predict_pc
    );

    modport slave (
        input  clr, if_pc, upd_valid, upd_pc, upd_taken, upd_jump, upd_target,
        output predict_jump, predict_pc
    );
endinterface

// File: rtl/branch_predictor.sv
// Fully-associative branch target buffer with 2-bit saturating direction counters.
// The lookup is combinational. Training happens on the clock edge from the EXE update port.
module branch_predictor #(
    parameter int ENTRIES = 8,
    parameter int PTR_W   = $clog2(ENTRIES)
) (
    input  logic               clk,
    input  logic               rst,
    branch_predictor_if.slave  bp
);

    logic [ENTRIES-1:0] valid_r;
    logic [29:0]        tag_r    [ENTRIES];
    logic [31:0]        target_r [ENTRIES];
    logic [1:0]         cnt_r    [ENTRIES];
    logic [PTR_W-1:0]   ptr_r;

    logic [ENTRIES-1:0] look_match_s;
    logic [ENTRIES-1:0] upd_match_s;
    logic               look_hit_s;
    logic               upd_hit_s;
    logic               free_avail_s;
    logic [PTR_W-1:0]   look_idx_s;
    logic [PTR_W-1:0]   upd_idx_s;
    logic [PTR_W-1:0]   free_idx_s;
    logic [PTR_W-1:0]   victim_s;
    logic               predict_jump_s;
    logic               unused_s;

    function automatic logic [PTR_W-1:0] lowest_index(input logic [ENTRIES-1:0] vec);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = PTR_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [1:0] cnt_inc(input logic [1:0] c);
        return (c == 2'd3) ? 2'd3 : c + 2'd1;
    endfunction

    function automatic logic [1:0] cnt_dec(input logic [1:0] c);
        return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    // Tag comparison for both the fetch lookup and the training port.
    always_comb begin
        look_match_s = '0;
        upd_match_s  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            look_match_s[i] = valid_r[i] && (tag_r[i] == bp.if_pc[31:2]);
            upd_match_s[i]  = valid_r[i] && (tag_r[i] == bp.upd_pc[31:2]);
        end
    end

    assign look_hit_s   = |look_match_s;
    assign upd_hit_s    = |upd_match_s;
    assign free_avail_s = ~&valid_r;
    assign look_idx_s   = lowest_index(look_match_s);
    assign upd_idx_s    = lowest_index(upd_match_s);
    assign free_idx_s   = lowest_index(~valid_r);
    // Empty slots are filled first; round-robin replacement is used only once the table is full.
    assign victim_s     = free_avail_s ? free_idx_s : ptr_r;

    assign predict_jump_s  = look_hit_s && cnt_r[look_idx_s][1];
    assign bp.predict_jump = predict_jump_s;
    assign bp.predict_pc   = predict_jump_s ? target_r[look_idx_s] : bp.if_pc + 32'd4;

    assign unused_s = ^bp.upd_pc[1:0];

    // Table state: async reset, clr flush, then hit training or miss allocation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= '0;
            ptr_r   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_r[i]    <= 30'd0;
                target_r[i] <= 32'd0;
                cnt_r[i]    <= 2'd0;
            end
        end else if (bp.clr) begin
            valid_r <= '0;
            ptr_r   <= '0;
        end else if (bp.upd_valid && upd_hit_s) begin
            if (bp.upd_taken) begin
                cnt_r[upd_idx_s]    <= cnt_inc(cnt_r[upd_idx_s]);
                target_r[upd_idx_s] <= bp.upd_target;
            end else begin
                cnt_r[upd_idx_s]    <= cnt_dec(cnt_r[upd_idx_s]);
            end
        end else if (bp.upd_valid && bp.upd_taken) begin
            valid_r[victim_s]  <= 1'b1;
            tag_r[victim_s]    <= bp.upd_pc[31:2];
            target_r[victim_s] <= bp.upd_target;
            cnt_r[victim_s]    <= bp.upd_jump ? 2'd3 : 2'd2;
            if (!free_avail_s) begin
                ptr_r <= ptr_r + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, hand-written corner
// sequences and randomized traffic compared against a behavioural table model.
module tb_branch_predictor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_predictor_if bus ();

    branch_predictor #(.ENTRIES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        uv;
        logic [31:0] up;
        logic        ut;
        logic        uj;
        logic [31:0] utg;
        logic        c;
        logic [31:0] ipc;
        logic        ej;
        logic [31:0] epc;
    } vec_t;

    vec_t vecs[$];

    // Reference model: an 8-slot table with plain integer counters.
    bit          m_valid [8];
    int unsigned m_tag   [8];
    logic [31:0] m_tgt   [8];
    int          m_cnt   [8];
    int          m_ptr;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = 32'd0;
            m_cnt[i]   = 0;
        end
        m_ptr = 0;
    endfunction

    function automatic void model_lookup(input logic [31:0] pc, output logic pj, output logic [31:0] ppc);
        pj  = 1'b0;
        ppc = pc + 32'd4;
        for (int i = 0; i < 8; i++) begin
            if (m_valid[i] && m_tag[i] == int'(pc >> 2)) begin
                if (m_cnt[i] >= 2) begin
                    pj  = 1'b1;
                    ppc = m_tgt[i];
                end
                break;
            end
        end
    endfunction

    function automatic void model_update();
        int hit;
        int slot;
        if (bus.clr) begin
            for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
            m_ptr = 0;
            return;
        end
        if (!bus.upd_valid) return;
        hit = -1;
        for (int i = 0; i < 8; i++) begin
            if (hit < 0 && m_valid[i] && m_tag[i] == int'(bus.upd_pc >> 2)) hit = i;
        end
        if (hit >= 0) begin
            if (bus.upd_taken) begin
                m_cnt[hit] = (m_cnt[hit] == 3) ? 3 : m_cnt[hit] + 1;
                m_tgt[hit] = bus.upd_target;
            end else begin
                m_cnt[hit] = (m_cnt[hit] == 0) ? 0 : m_cnt[hit] - 1;
            end
        end else if (bus.upd_taken) begin
            slot = -1;
            for (int i = 0; i < 8; i++) begin
                if (slot < 0 && !m_valid[i]) slot = i;
            end
            if (slot < 0) begin
                slot  = m_ptr;
                m_ptr = (m_ptr + 1) % 8;
            end
            m_valid[slot] = 1'b1;
            m_tag[slot]   = bus.upd_pc >> 2;
            m_tgt[slot]   = bus.upd_target;
            m_cnt[slot]   = bus.upd_jump ? 3 : 2;
        end
    endfunction

    function automatic void addv(input logic uv, input logic [31:0] up, input logic ut, input logic uj,
                                 input logic [31:0] utg, input logic c, input logic [31:0] ipc,
                                 input logic ej, input logic [31:0] epc);
        vec_t v;
        v = '{uv, up, ut, uj, utg, c, ipc, ej, epc};
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic uv, input logic [31:0] up, input logic ut, input logic uj,
                         input logic [31:0] utg, input logic c, input logic [31:0] ipc);
        bus.upd_valid  = uv;
        bus.upd_pc     = up;
        bus.upd_taken  = ut;
        bus.upd_jump   = uj;
        bus.upd_target = utg;
        bus.clr        = c;
        bus.if_pc      = ipc;
    endtask

    task automatic check(input string name, input logic ej, input logic [31:0] epc);
        n_tests++;
        if (bus.predict_jump !== ej || bus.predict_pc !== epc) begin
            n_fail++;
            $display("FAIL %s: if_pc=%h got jump=%0b pc=%h, want jump=%0b pc=%h",
                     name, bus.if_pc, bus.predict_jump, bus.predict_pc, ej, epc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic cyc(input string name, input logic uv, input logic [31:0] up, input logic ut,
                       input logic uj, input logic [31:0] utg, input logic c, input logic [31:0] ipc,
                       input logic ej, input logic [31:0] epc);
        drive(uv, up, ut, uj, utg, c, ipc);
        #1;
        check(name, ej, epc);
        tick();
    endtask

    task automatic look(input string name, input logic [31:0] ipc, input logic ej, input logic [31:0] epc);
        cyc(name, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, ipc, ej, epc);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic        pj;
        logic [31:0] ppc;
        logic [31:0] a;

        // uv, upd_pc, taken, jump, target, clr, if_pc, exp_jump, exp_pc
        addv(1'b0, 32'h00, 1'b0, 1'b0, 32'h000, 1'b0, 32'h100, 1'b0, 32'h104);
        addv(1'b1, 32'h40, 1'b1, 1'b0, 32'h080, 1'b0, 32'h040, 1'b0, 32'h044);
        addv(1'b1, 32'h40, 1'b0, 1'b0, 32'h000, 1'b0, 32'h040, 1'b1, 32'h080);
        addv(1'b0, 32'h00, 1'b0, 1'b0, 32'h000, 1'b0, 32'h040, 1'b0, 32'h044);
        addv(1'b1, 32'h40, 1'b1, 1'b0, 32'h080, 1'b0, 32'h040, 1'b0, 32'h044);
        addv(1'b1, 32'h40, 1'b1, 1'b0, 32'h080, 1'b0, 32'h040, 1'b1, 32'h080);
        addv(1'b1, 32'h40, 1'b1, 1'b0, 32'h080, 1'b0, 32'h040, 1'b1, 32'h080);
        addv(1'b1, 32'h40, 1'b1, 1'b0, 32'h080, 1'b0, 32'h040, 1'b1, 32'h080);
        addv(1'b1, 32'h40, 1'b0, 1'b0, 32'h000, 1'b0, 32'h040, 1'b1, 32'h080);
        addv(1'b0, 32'h00, 1'b0, 1'b0, 32'h000, 1'b0, 32'h040, 1'b1, 32'h080);
        addv(1'b1, 32'h40, 1'b0, 1'b0, 32'h000, 1'b0, 32'h040, 1'b1, 32'h080);
        addv(1'b1, 32'h40, 1'b0, 1'b0, 32'h000, 1'b0, 32'h040, 1'b0, 32'h044);
        addv(1'b1, 32'h40, 1'b0, 1'b0, 32'h000, 1'b0, 32'h040, 1'b0, 32'h044);
        addv(1'b1, 32'h40, 1'b1, 1'b0, 32'h080, 1'b0, 32'h040, 1'b0, 32'h044);
        addv(1'b0, 32'h00, 1'b0, 1'b0, 32'h000, 1'b0, 32'h040, 1'b0, 32'h044);
        addv(1'b1, 32'h40, 1'b1, 1'b0, 32'h090, 1'b0, 32'h040, 1'b0, 32'h044);
        addv(1'b1, 32'h40, 1'b1, 1'b0, 32'h090, 1'b0, 32'h040, 1'b1, 32'h090);
        addv(1'b1, 32'h40, 1'b0, 1'b0, 32'h123, 1'b0, 32'h040, 1'b1, 32'h090);
        addv(1'b0, 32'h00, 1'b0, 1'b0, 32'h000, 1'b0, 32'h040, 1'b1, 32'h090);
        addv(1'b0, 32'h00, 1'b0, 1'b0, 32'h000, 1'b0, 32'h042, 1'b1, 32'h090);
        addv(1'b1, 32'h10, 1'b1, 1'b1, 32'h200, 1'b0, 32'h010, 1'b0, 32'h014);
        addv(1'b1, 32'h10, 1'b0, 1'b0, 32'h000, 1'b0, 32'h010, 1'b1, 32'h200);
        addv(1'b0, 32'h00, 1'b0, 1'b0, 32'h000, 1'b0, 32'h010, 1'b1, 32'h200);
        addv(1'b1, 32'h60, 1'b0, 1'b0, 32'h700, 1'b0, 32'h060, 1'b0, 32'h064);
        addv(1'b0, 32'h00, 1'b0, 1'b0, 32'h000, 1'b0, 32'h060, 1'b0, 32'h064);

        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h100);
        rst = 1'b0;
        model_reset();
        #1;
        check("reset_outputs", 1'b0, 32'h104);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            cyc($sformatf("vec%0d", i), vecs[i].uv, vecs[i].up, vecs[i].ut, vecs[i].uj,
                vecs[i].utg, vecs[i].c, vecs[i].ipc, vecs[i].ej, vecs[i].epc);
        end

        // Reset acts immediately and mid-operation, leaving the table empty.
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h40);
        #1;
        check("pre_reset_hit", 1'b1, 32'h90);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("async_reset", 1'b0, 32'h44);
        @(negedge clk);
        rst = 1'b1;
        look("after_reset_empty", 32'h40, 1'b0, 32'h44);

        // Fill all eight slots, then force round-robin replacement.
        for (int k = 0; k < 8; k++) begin
            a = 32'(4 * k);
            cyc("fill_same_cycle_miss", 1'b1, a, 1'b1, 1'b0, 32'h1000 + a, 1'b0, a, 1'b0, a + 32'd4);
        end
        for (int k = 0; k < 8; k++) begin
            a = 32'(4 * k);
            look("fill_hit", a, 1'b1, 32'h1000 + a);
        end
        cyc("alloc_20", 1'b1, 32'h20, 1'b1, 1'b0, 32'h1020, 1'b0, 32'h20, 1'b0, 32'h24);
        look("evicted_00", 32'h00, 1'b0, 32'h04);
        look("new_20", 32'h20, 1'b1, 32'h1020);
        look("kept_04", 32'h04, 1'b1, 32'h1004);
        cyc("alloc_24", 1'b1, 32'h24, 1'b1, 1'b0, 32'h1024, 1'b0, 32'h24, 1'b0, 32'h28);
        look("evicted_04", 32'h04, 1'b0, 32'h08);
        look("new_24", 32'h24, 1'b1, 32'h1024);
        look("kept_08", 32'h08, 1'b1, 32'h1008);

        // clr beats a simultaneous allocation and rewinds the pointer.
        cyc("clr_cycle", 1'b1, 32'h300, 1'b1, 1'b0, 32'h500, 1'b1, 32'h08, 1'b1, 32'h1008);
        look("clr_drops_update", 32'h300, 1'b0, 32'h304);
        look("clr_empties", 32'h08, 1'b0, 32'h0C);
        look("pc_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);
        for (int k = 0; k < 9; k++) begin
            a = 32'h400 + 32'(4 * k);
            cyc("refill", 1'b1, a, 1'b1, 1'b0, 32'h2000 + a, 1'b0, 32'h0, 1'b0, 32'h4);
        end
        look("ptr0_evicts_first", 32'h400, 1'b0, 32'h404);
        look("ptr0_keeps_second", 32'h404, 1'b1, 32'h2404);
        look("ptr0_keeps_third", 32'h408, 1'b1, 32'h2408);
        look("ptr0_ninth", 32'h420, 1'b1, 32'h2420);

        // Randomized traffic against the model, with a small PC pool to force evictions.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic        uv, ut, uj, c;
            logic [31:0] up, utg, ipc;
            uv  = 1'($urandom_range(0, 1));
            up  = 32'h1000 + 32'(4 * $urandom_range(0, 15));
            uj  = ($urandom_range(0, 3) == 0);
            ut  = uj ? 1'b1 : 1'($urandom_range(0, 1));
            utg = $urandom;
            c   = ($urandom_range(0, 49) == 0);
            ipc = 32'h1000 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) ipc = up;
            drive(uv, up, ut, uj, utg, c, ipc);
            #1;
            model_lookup(ipc, pj, ppc);
            check("rand", pj, ppc);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
